// File: rtl/timer_pkg.sv
// timer_pkg: shared encodings for the memory-mapped countdown timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  localparam logic [3:0] OFF_CTRL = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT = 4'h8;
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD = 2'b01;
  localparam int CTRL_EN = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM = 3;
endpackage

// File: rtl/timer_device.sv
// timer_device: bus-mapped countdown timer with one-shot/auto-reload modes and a maskable irq
module timer_device
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);
  state_t state;
  logic [3:0] ctrl;
  logic [31:0] preset, count;
  logic irq_flag;
  logic [1:0] sel;
  logic wr, wr_ctrl, wr_preset, en, reload;
  logic unused_addr;
  assign unused_addr = ^addr[1:0];
  assign sel = addr[3:2];
  assign hit = (addr[31:4] == BASE_ADDR[31:4]) && (sel != 2'b11);
  assign wr = hit && (byteen == 4'hF);
  assign wr_ctrl = wr && (sel == OFF_CTRL[3:2]);
  assign wr_preset = wr && (sel == OFF_PRESET[3:2]);
  assign en = ctrl[CTRL_EN];
  assign reload = ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD;
  assign irq = irq_flag & ctrl[CTRL_IM];
  always_comb
    rdata = sel == OFF_CTRL[3:2]   ? {28'b0, ctrl} :
            sel == OFF_PRESET[3:2] ? preset :
            sel == OFF_COUNT[3:2]  ? count : '0;
  // Bus stores take priority over FSM updates to ctrl and irq_flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ctrl <= '0;
      preset <= '0;
      count <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= wdata[3:0];
      else if (state == INT && !reload) ctrl[CTRL_EN] <= 1'b0;
      if (wr_preset) preset <= wdata;
      if (wr_ctrl || wr_preset) irq_flag <= 1'b0;
      else if (state == CNT && en && count <= 32'd1) irq_flag <= 1'b1;
      else if (state == INT && reload) irq_flag <= 1'b0;
      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT:
          if (!en) state <= IDLE;
          else if (count > 32'd1) count <= count - 32'd1;
          else begin
            count <= '0;
            state <= INT;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: vector table, directed timing sequences and randomized model check for timer_device
module tb_timer_device;
  localparam logic [31:0] BASE = 32'h0000_7F00;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] addr = BASE;
  logic [3:0] byteen = 4'h0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic hit, irq;
  int checks = 0;
  int errors = 0;

  timer_device dut (
    .clk(clk), .reset(reset), .addr(addr), .byteen(byteen),
    .wdata(wdata), .rdata(rdata), .hit(hit), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        hit;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[16];

  // Reference model: a run is tracked by its age in cycles since it armed;
  // COUNT and the interrupt deadline follow arithmetically from the loaded value.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count, m_lv;
  logic        m_flag;
  longint      m_age, m_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    byteen = 4'hF;
    tick();
    byteen = 4'h0;
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return (a[31:4] == BASE[31:4]) && (a[3:2] != 2'b11);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    case (a[3:2])
      2'b00: return {28'b0, m_ctrl};
      2'b01: return m_preset;
      2'b10: return m_count;
      default: return '0;
    endcase
  endfunction

  task automatic model_step();
    logic [3:0] nc;
    logic [31:0] np, ncount;
    logic nf;
    longint na;
    nc = m_ctrl; np = m_preset; ncount = m_count; nf = m_flag; na = m_age;
    if (m_age < 0) begin
      if (m_ctrl[0]) na = 1;
    end else if (m_age == 1) begin
      ncount = m_preset;
      m_lv = m_preset;
      m_d = (m_preset == 0 ? 1 : longint'(m_preset)) + 2;
      na = 2;
    end else if (m_age == m_d) begin
      if (m_ctrl[2:1] == 2'b01) nf = 1'b0;
      else nc[0] = 1'b0;
      na = -1;
    end else if (!m_ctrl[0]) begin
      na = -1;
    end else begin
      na = m_age + 1;
      if (na == m_d) begin
        ncount = '0;
        nf = 1'b1;
      end else ncount = 32'(longint'(m_lv) - (na - 2));
    end
    if (m_hit(addr) && byteen == 4'hF && addr[3:2] == 2'b00) begin
      nc = wdata[3:0];
      nf = 1'b0;
    end
    if (m_hit(addr) && byteen == 4'hF && addr[3:2] == 2'b01) begin
      np = wdata;
      nf = 1'b0;
    end
    m_ctrl = nc; m_preset = np; m_count = ncount; m_flag = nf; m_age = na;
  endtask

  initial begin
    int q[$];
    int ok;
    logic [31:0] off;
    int r;
    tbl[0]  = '{BASE + 32'h0,  4'h0, 32'h0,          1'b1, 32'h0};
    tbl[1]  = '{BASE + 32'h4,  4'h0, 32'h0,          1'b1, 32'h0};
    tbl[2]  = '{BASE + 32'h8,  4'h0, 32'h0,          1'b1, 32'h0};
    tbl[3]  = '{BASE + 32'hC,  4'h0, 32'h0,          1'b0, 32'h0};
    tbl[4]  = '{BASE + 32'h4,  4'h3, 32'h55,         1'b1, 32'h0};
    tbl[5]  = '{BASE + 32'h4,  4'h0, 32'h0,          1'b1, 32'h0};
    tbl[6]  = '{BASE + 32'h8,  4'hF, 32'h77,         1'b1, 32'h0};
    tbl[7]  = '{BASE + 32'h8,  4'h0, 32'h0,          1'b1, 32'h0};
    tbl[8]  = '{BASE + 32'h10, 4'hF, 32'hF,          1'b0, 32'h0};
    tbl[9]  = '{BASE + 32'h0,  4'h0, 32'h0,          1'b1, 32'h0};
    tbl[10] = '{BASE + 32'h4,  4'hF, 32'h1234_5678,  1'b1, 32'h0};
    tbl[11] = '{BASE + 32'h5,  4'h0, 32'h0,          1'b1, 32'h1234_5678};
    tbl[12] = '{BASE + 32'h0,  4'hF, 32'h0000_0F06,  1'b1, 32'h0};
    tbl[13] = '{BASE + 32'h3,  4'h0, 32'h0,          1'b1, 32'h6};
    tbl[14] = '{BASE + 32'h0,  4'hF, 32'h0,          1'b1, 32'h6};
    tbl[15] = '{BASE + 32'h0,  4'h0, 32'h0,          1'b1, 32'h0};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 16; i++) begin
      addr = tbl[i].addr;
      byteen = tbl[i].be;
      wdata = tbl[i].wd;
      #1;
      check($sformatf("tbl%0d_hit", i), 32'(hit), 32'(tbl[i].hit));
      check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rd);
      check($sformatf("tbl%0d_irq", i), 32'(irq), 32'h0);
      tick();
    end
    byteen = 4'h0;

    wr(BASE + 32'h4, 32'd3);
    wr(BASE + 32'h0, 32'h9);
    addr = BASE + 32'h8;
    tick();
    tick(); check("os_count_idx2", rdata, 32'd3);
    tick(); check("os_count_idx3", rdata, 32'd2);
    tick(); check("os_count_idx4", rdata, 32'd1);
    check("os_irq_idx4", 32'(irq), 32'h0);
    tick(); check("os_count_idx5", rdata, 32'd0);
    check("os_irq_idx5", 32'(irq), 32'h1);
    repeat (3) tick();
    check("os_irq_held", 32'(irq), 32'h1);
    addr = BASE;
    #1 check("os_ctrl_after", rdata, 32'h8);
    wr(BASE, 32'h0);
    check("os_irq_cleared", 32'(irq), 32'h0);

    wr(BASE + 32'h4, 32'd2);
    wr(BASE + 32'h0, 32'hB);
    for (int i = 0; i < 30; i++) begin
      if (irq) q.push_back(i);
      if (i < 29) tick();
    end
    check("ar_pulses", 32'(q.size()), 32'd6);
    check("ar_first", q.size() > 0 ? 32'(q[0]) : 32'hFFFF_FFFF, 32'd4);
    ok = 1;
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != 5) ok = 0;
    check("ar_spacing", 32'(ok), 32'd1);
    #1 check("ar_ctrl_en_kept", rdata, 32'hB);
    wr(BASE, 32'h0);

    wr(BASE + 32'h4, 32'd1);
    wr(BASE + 32'h0, 32'h1);
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      if (irq) ok = 0;
      tick();
    end
    check("mask_irq_low", 32'(ok), 32'd1);
    addr = BASE;
    #1 check("mask_ctrl_en_cleared", rdata, 32'h0);
    wr(BASE, 32'h8);
    check("mask_irq_after_im", 32'(irq), 32'h0);
    wr(BASE, 32'h0);

    wr(BASE + 32'h4, 32'd100);
    wr(BASE + 32'h0, 32'h9);
    addr = BASE + 32'h8;
    repeat (10) tick();
    check("ar_mid_count", rdata, 32'd92);
    #2 reset = 1'b1;
    #1 check("async_count", rdata, 32'h0);
    addr = BASE;
    #1 check("async_ctrl", rdata, 32'h0);
    check("async_irq", 32'(irq), 32'h0);
    addr = BASE + 32'h4;
    #1 check("async_preset", rdata, 32'h0);
    reset = 1'b0;
    addr = BASE + 32'h8;
    repeat (5) tick();
    check("async_no_restart", rdata, 32'h0);

    m_ctrl = '0; m_preset = '0; m_count = '0; m_lv = '0; m_flag = 1'b0;
    m_age = -1; m_d = 0;
    for (int i = 0; i < 800; i++) begin
      off = 32'($urandom_range(0, 4)) * 4 + 32'($urandom_range(0, 3));
      addr = BASE + off;
      r = $urandom_range(0, 11);
      byteen = r == 0 ? 4'hF : r == 1 ? 4'h3 : 4'h0;
      wdata = addr[3:2] == 2'b01 ? 32'($urandom_range(0, 5)) : $urandom;
      #1;
      check("rnd_hit", 32'(hit), 32'(m_hit(addr)));
      check("rnd_rdata", rdata, m_rdata(addr));
      check("rnd_irq", 32'(irq), 32'(m_flag & m_ctrl[3]));
      model_step();
      tick();
    end
    byteen = 4'h0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_device.md
Name: timer_device

Overview:
- Memory-mapped countdown timer on the CPU data bus, acting as the responder side of the CPU store/load port.
- Sources one hardware interrupt line, which the system wires to one bit of the CPU HWInt input.
- Decodes its own 12-byte window, accepts full-word stores, and returns combinational read data.
- Runs a 4-state counting FSM with one-shot and auto-reload modes.

Parameters:
- BASE_ADDR, 32'h0000_7F00, word-aligned base of the register window; bits [3:0] must be 0.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- addr, input, 32, byte address from CPU (ALU result in MEM stage).
- byteen, input, 4, store byte enables from CPU; 4'h0 means no store.
- wdata, input, 32, store data from CPU.
- rdata, output, 32, combinational read data.
- hit, output, 1, addr falls in this device's window.
- irq, output, 1, interrupt request to CPU HWInt.

Behaviour:
- Register map, offset from BASE_ADDR:
  - 0x0 CTRL: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1 = enabled); bits [31:4] read 0.
  - 0x4 PRESET: 32-bit reload value.
  - 0x8 COUNT: 32-bit current count; read-only.
- hit = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11). Combinational; ignores addr[1:0].
- rdata is combinational from addr[3:2]:
  - 00: {28'b0, ctrl}
  - 01: preset
  - 10: count
  - 11: 0
  - rdata is also driven when hit=0; the bus selects on hit.
- Store: wr = hit && (byteen == 4'hF). Partial-byte stores (byteen neither 0 nor F) are ignored entirely. Stores to COUNT are ignored.
- CTRL write: ctrl <= wdata[3:0] and irq_flag <= 0.
- PRESET write: preset <= wdata and irq_flag <= 0.
- irq = irq_flag & ctrl[3].
- Reset values: state=IDLE, ctrl=0, preset=0, count=0, irq_flag=0. Hence rdata reflects zeros, irq=0, hit depends only on addr.
- FSM (evaluated after any same-cycle store; the new CTRL value takes effect next cycle):
  - IDLE: EN=1 -> LOAD; otherwise stay.
  - LOAD: count <= preset; -> CNT.
  - CNT:
    - EN=0 -> IDLE; count holds.
    - count > 1 -> count <= count-1; stay.
    - count <= 1 -> count <= 0; irq_flag <= 1; -> INT.
  - INT, MODE 00: ctrl[0] <= 0; -> IDLE; irq_flag stays 1 until a CTRL/PRESET write.
  - INT, MODE 01: irq_flag <= 0, so irq is a 1-cycle pulse during INT; -> IDLE; EN remains, so the cycle reloads.
- Period: with preset=N (N>=1), IRQ asserts N+2 cycles after the first IDLE cycle with EN=1. preset=0 behaves as preset=1. Auto-reload repeats every N+3 cycles.
- Same-cycle store vs FSM:
  - A CTRL store wins over the INT-state EN clear.
  - A store that clears irq_flag wins over CNT setting it; the FSM still moves to INT.
- Clearing EN mid-count freezes COUNT. Setting it again reloads from PRESET via IDLE->LOAD.
- Reset asserted mid-count returns everything to reset values immediately, without waiting for a clock edge.
- Width: COUNT decrement is unsigned 32-bit and never wraps below 0.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding (IDLE, LOAD, CNT, INT)
  - register offsets (0x0, 0x4, 0x8)
  - MODE constants
  - CTRL bit indices
- Single module; no natural sub-module. Bridge-side integration of hit/rdata muxing lives outside this block.

Test Plan:
- Reset then read: addr=BASE+0/4/8 -> rdata=0, irq=0, hit=1; addr=BASE+0xC -> hit=0.
- One-shot: write PRESET=3, then CTRL=4'b1001 -> COUNT reads 3,2,1,0; irq rises in INT and stays 1; CTRL reads 4'b1000 afterwards; writing CTRL=0 drops irq next cycle.
- Auto-reload: PRESET=2, CTRL=4'b1011 -> irq 1-cycle pulses exactly 5 cycles apart; EN stays 1.
- Mask: PRESET=1, CTRL=4'b0001 -> irq stays 0; a later CTRL write of 4'b1000 clears the flag, so irq still 0.
- Bus rules: byteen=4'h3 write to PRESET -> PRESET unchanged; write to COUNT -> COUNT unchanged; write to BASE+0x10 -> hit=0, no state change.
- Async reset: assert reset mid-count, between clock edges -> count, ctrl, irq read 0 before the next edge; the FSM restarts only after a new CTRL write.
